// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared widths and fixed-point helpers for the multi-channel IIR filter
//
// Purpose : accumulator width rule, round-half-up arithmetic shift and
//           output saturation, evaluated on a wide signed working type so
//           one set of helpers serves every parameterisation.
// Contents: wide_t, clip_t, acc_w(), rnd_shr(), sat_clip()
package iir_pkg;

    localparam int WIDE = 64;

    typedef logic signed [WIDE-1:0] wide_t;

    typedef struct packed {
        logic signed [WIDE-1:0] val;
        logic                   clip;
    } clip_t;

    // Three products summed: the widest product plus two carry bits.
    function automatic int acc_w(input int xw, input int yw, input int cw);
        return ((xw > yw) ? xw : yw) + cw + 2;
    endfunction

    // Round half up, then arithmetic shift; frac == 0 passes the value through.
    function automatic wide_t rnd_shr(input wide_t v, input int frac);
        wide_t half;
        if (frac <= 0) begin
            return v;
        end
        half = wide_t'(1) <<< (frac - 1);
        return (v + half) >>> frac;
    endfunction

    // Clip to the signed yw-bit range and report whether clipping happened.
    function automatic clip_t sat_clip(input wide_t v, input int yw);
        clip_t r;
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (yw - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) begin
            r.val  = hi;
            r.clip = 1'b1;
        end else if (v < lo) begin
            r.val  = lo;
            r.clip = 1'b1;
        end else begin
            r.val  = v;
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_mac_sat.sv
// rtl/iir_mac_sat.sv - combinational multiply-accumulate, rounding and saturation
//
// Purpose : ynew = sat(round((b0*x + b1*x_d + a1*y_d) >>> FRAC)) for one channel.
// Ports   : x, x_d (XW)  current and previous sample
//           y_d (YW)     previous output of the same channel
//           b0, b1, a1   shared coefficients (CW)
//           ynew (YW)    new output, sat: ynew was clipped
module iir_mac_sat
    import iir_pkg::*;
#(
    parameter int XW   = 4,
    parameter int CW   = 4,
    parameter int YW   = 8,
    parameter int FRAC = 0
) (
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] x_d,
    input  logic signed [YW-1:0] y_d,
    input  logic signed [CW-1:0] b0,
    input  logic signed [CW-1:0] b1,
    input  logic signed [CW-1:0] a1,
    output logic signed [YW-1:0] ynew,
    output logic                 sat
);

    localparam int ACCW = acc_w(XW, YW, CW);

    logic signed [ACCW-1:0] acc;
    clip_t                  clipped;

    // Operands are sign-extended to ACCW first so no product or sum can wrap.
    always_comb begin
        acc = ACCW'(b0) * ACCW'(x)
            + ACCW'(b1) * ACCW'(x_d)
            + ACCW'(a1) * ACCW'(y_d);
    end

    always_comb begin
        clipped = sat_clip(rnd_shr(wide_t'(acc), FRAC), YW);
        ynew    = clipped.val[YW-1:0];
        sat     = clipped.clip;
    end

endmodule

// File: rtl/iir_mc_filter.sv
// rtl/iir_mc_filter.sv - time-interleaved multi-channel first-order IIR filter
//
// Purpose : per-channel x[n-1]/y[n-1] state, control priority
//           (reset_n > clr > sleep > in_valid) and registered outputs.
// Ports   : clk, reset_n (sync, active low), clr (clear all channel state),
//           sleep (freeze), in_valid/in_ch/x (sample in), b0/b1/a1 (coefficients),
//           out_valid/out_ch/y/sat (result, 1-cycle latency), ch_err (bad channel).
module iir_mc_filter
    import iir_pkg::*;
#(
    parameter int XW   = 4,
    parameter int CW   = 4,
    parameter int YW   = 8,
    parameter int FRAC = 0,
    parameter int NCH  = 1,
    parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 sleep,
    input  logic                 in_valid,
    input  logic [CHW-1:0]       in_ch,
    input  logic signed [XW-1:0] x,
    input  logic signed [CW-1:0] b0,
    input  logic signed [CW-1:0] b1,
    input  logic signed [CW-1:0] a1,
    output logic                 out_valid,
    output logic [CHW-1:0]       out_ch,
    output logic signed [YW-1:0] y,
    output logic                 sat,
    output logic                 ch_err
);

    localparam logic [CHW:0] NCH_V = (CHW + 1)'(NCH);

    logic signed [XW-1:0] x_d [NCH];
    logic signed [YW-1:0] y_d [NCH];

    logic                 ch_ok;
    logic signed [XW-1:0] cur_xd;
    logic signed [YW-1:0] cur_yd;
    logic signed [YW-1:0] ynew;
    logic                 ynew_sat;

    assign ch_ok = ({1'b0, in_ch} < NCH_V);

    // Decoded read of the addressed channel; an out-of-range index reads zero.
    always_comb begin
        cur_xd = '0;
        cur_yd = '0;
        for (int c = 0; c < NCH; c++) begin
            if (in_ch == CHW'(c)) begin
                cur_xd = x_d[c];
                cur_yd = y_d[c];
            end
        end
    end

    iir_mac_sat #(
        .XW   (XW),
        .CW   (CW),
        .YW   (YW),
        .FRAC (FRAC)
    ) u_mac (
        .x    (x),
        .x_d  (cur_xd),
        .y_d  (cur_yd),
        .b0   (b0),
        .b1   (b1),
        .a1   (a1),
        .ynew (ynew),
        .sat  (ynew_sat)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                x_d[c] <= '0;
                y_d[c] <= '0;
            end
            y         <= '0;
            out_ch    <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            ch_err    <= 1'b0;
        end else if (clr) begin
            for (int c = 0; c < NCH; c++) begin
                x_d[c] <= '0;
                y_d[c] <= '0;
            end
            out_valid <= 1'b0;
            ch_err    <= 1'b0;
        end else if (sleep) begin
            out_valid <= 1'b0;
            ch_err    <= 1'b0;
        end else if (in_valid && ch_ok) begin
            for (int c = 0; c < NCH; c++) begin
                if (in_ch == CHW'(c)) begin
                    x_d[c] <= x;
                    y_d[c] <= ynew;   // the clipped value is what feeds back
                end
            end
            y         <= ynew;
            out_ch    <= in_ch;
            sat       <= ynew_sat;
            out_valid <= 1'b1;
            ch_err    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            ch_err    <= in_valid;  // in_valid here means the channel was out of range
        end
    end

endmodule

// File: tb/tb_iir_mc_filter.sv
// tb/tb_iir_mc_filter.sv - self-checking bench for iir_mc_filter (three parameterisations)
module tb_iir_mc_filter;

    logic              clk;
    logic              reset_n;
    logic              clr;
    logic              sleep;
    logic              in_valid;
    logic [1:0]        in_ch;
    logic signed [3:0] x;
    logic signed [3:0] b0;
    logic signed [3:0] b1;
    logic signed [3:0] a1;

    logic              vld_o [3];
    logic signed [7:0] y_o   [3];
    logic              sat_o [3];
    logic              err_o [3];
    logic [0:0]        cha;
    logic [0:0]        chb;
    logic [1:0]        chc;
    int                ch_o  [3];

    int tests;
    int fails;
    bit armed;

    // dut 0: defaults; dut 1: FRAC=2; dut 2: NCH=3
    iir_mc_filter u_a (
        .clk(clk), .reset_n(reset_n), .clr(clr), .sleep(sleep), .in_valid(in_valid),
        .in_ch(in_ch[0:0]), .x(x), .b0(b0), .b1(b1), .a1(a1),
        .out_valid(vld_o[0]), .out_ch(cha), .y(y_o[0]), .sat(sat_o[0]), .ch_err(err_o[0])
    );

    iir_mc_filter #(.FRAC(2)) u_b (
        .clk(clk), .reset_n(reset_n), .clr(clr), .sleep(sleep), .in_valid(in_valid),
        .in_ch(in_ch[0:0]), .x(x), .b0(b0), .b1(b1), .a1(a1),
        .out_valid(vld_o[1]), .out_ch(chb), .y(y_o[1]), .sat(sat_o[1]), .ch_err(err_o[1])
    );

    iir_mc_filter #(.NCH(3)) u_c (
        .clk(clk), .reset_n(reset_n), .clr(clr), .sleep(sleep), .in_valid(in_valid),
        .in_ch(in_ch), .x(x), .b0(b0), .b1(b1), .a1(a1),
        .out_valid(vld_o[2]), .out_ch(chc), .y(y_o[2]), .sat(sat_o[2]), .ch_err(err_o[2])
    );

    always_comb begin
        ch_o[0] = int'(cha);
        ch_o[1] = int'(chb);
        ch_o[2] = int'(chc);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int nch_p  [3] = '{1, 1, 3};
    int frac_p [3] = '{0, 2, 0};
    int mask_p [3] = '{1, 1, 3};

    int xd [3][16];
    int yd [3][16];
    int ey [3];
    int ech[3];
    int ev [3];
    int es [3];
    int ee [3];

    function automatic int floor_div(input int n, input int d);
        int q;
        q = n / d;
        if (n < 0 && (n % d) != 0) q = q - 1;
        return q;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!reset_n) begin
                for (int c = 0; c < 16; c++) begin
                    xd[d][c] = 0;
                    yd[d][c] = 0;
                end
                ey[d] = 0; ech[d] = 0; ev[d] = 0; es[d] = 0; ee[d] = 0;
            end else if (clr) begin
                for (int c = 0; c < 16; c++) begin
                    xd[d][c] = 0;
                    yd[d][c] = 0;
                end
                ev[d] = 0; ee[d] = 0;
            end else if (sleep) begin
                ev[d] = 0; ee[d] = 0;
            end else if (in_valid) begin
                int c;
                int acc;
                int r;
                c = int'(in_ch) & mask_p[d];
                if (c < nch_p[d]) begin
                    acc = int'(b0) * int'(x) + int'(b1) * xd[d][c] + int'(a1) * yd[d][c];
                    if (frac_p[d] > 0)
                        r = floor_div(acc + (1 << (frac_p[d] - 1)), 1 << frac_p[d]);
                    else
                        r = acc;
                    es[d] = (r > 127 || r < -128) ? 1 : 0;
                    if (r > 127) r = 127;
                    if (r < -128) r = -128;
                    xd[d][c] = int'(x);
                    yd[d][c] = r;
                    ey[d] = r; ech[d] = c; ev[d] = 1; ee[d] = 0;
                end else begin
                    ev[d] = 0; ee[d] = 1;
                end
            end else begin
                ev[d] = 0; ee[d] = 0;
            end
        end
    end

    // ---------------- cycle compare ----------------
    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("dut%0d.out_valid", d), int'(vld_o[d]), ev[d]);
                chk($sformatf("dut%0d.ch_err", d), int'(err_o[d]), ee[d]);
                chk($sformatf("dut%0d.y", d), int'(y_o[d]), ey[d]);
                chk($sformatf("dut%0d.out_ch", d), ch_o[d], ech[d]);
                chk($sformatf("dut%0d.sat", d), int'(sat_o[d]), es[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic rn, input logic cl, input logic sl, input logic v,
                       input logic [1:0] ch, input int xx);
        reset_n  = rn;
        clr      = cl;
        sleep    = sl;
        in_valid = v;
        in_ch    = ch;
        x        = 4'(xx);
        @(negedge clk);
    endtask

    task automatic coef(input int c0, input int c1, input int c2);
        b0 = 4'(c0);
        b1 = 4'(c1);
        a1 = 4'(c2);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        armed = 1'b0;
        reset_n = 1'b0; clr = 1'b0; sleep = 1'b0; in_valid = 1'b0; in_ch = '0; x = '0;
        coef(0, 0, 0);
        @(negedge clk);

        cyc(0, 0, 0, 0, 0, 0);
        armed = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        chk("reset y", int'(y_o[0]), 0);
        chk("reset out_valid", int'(vld_o[0]), 0);

        // b0=3, a1=4, x=5 held
        coef(3, 0, 4);
        cyc(1, 0, 0, 1, 0, 5);
        chk("t1 y0", int'(y_o[0]), 15);
        cyc(1, 0, 0, 1, 0, 5);
        chk("t1 y1", int'(y_o[0]), 75);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 1, 0, 5);
            chk("sleep out_valid", int'(vld_o[0]), 0);
            chk("sleep y", int'(y_o[0]), 75);
        end
        cyc(1, 0, 0, 1, 0, 5);
        chk("t1 y2", int'(y_o[0]), 127);
        chk("t1 sat2", int'(sat_o[0]), 1);
        cyc(1, 0, 0, 1, 0, 5);
        chk("t1 y3", int'(y_o[0]), 127);
        cyc(1, 1, 0, 1, 0, 5);
        chk("clr out_valid", int'(vld_o[0]), 0);
        chk("clr y hold", int'(y_o[0]), 127);
        cyc(1, 0, 0, 1, 0, 5);
        chk("after clr y", int'(y_o[0]), 15);

        // reset mid-stream while valid
        cyc(1, 0, 0, 1, 0, 5);
        cyc(0, 0, 0, 1, 0, 5);
        chk("mid reset y", int'(y_o[0]), 0);
        chk("mid reset valid", int'(vld_o[0]), 0);
        cyc(1, 0, 0, 1, 0, 5);
        chk("restart y", int'(y_o[0]), 15);

        // b0=2, b1=-2, a1=-4, x=5 held
        cyc(1, 1, 0, 0, 0, 0);
        coef(2, -2, -4);
        cyc(1, 0, 0, 1, 0, 5);
        chk("t2 y0", int'(y_o[0]), 10);
        cyc(1, 0, 0, 1, 0, 5);
        chk("t2 y1", int'(y_o[0]), -40);
        cyc(1, 0, 0, 1, 0, 5);
        chk("t2 y2", int'(y_o[0]), 127);
        chk("t2 sat2", int'(sat_o[0]), 1);
        cyc(1, 0, 0, 1, 0, 5);
        chk("t2 y3", int'(y_o[0]), -128);
        chk("t2 sat3", int'(sat_o[0]), 1);
        chk("t2 valid", int'(vld_o[0]), 1);

        // out-of-range channel
        cyc(1, 0, 0, 1, 3, 5);
        chk("ch_err pulse", int'(err_o[2]), 1);
        chk("ch_err no valid", int'(vld_o[2]), 0);
        chk("ch_err y hold", int'(y_o[2]), -128);
        cyc(1, 0, 0, 0, 0, 0);
        chk("ch_err clears", int'(err_o[2]), 0);

        // interleaved channels on the NCH=3 instance
        cyc(1, 1, 0, 0, 0, 0);
        coef(1, 0, 1);
        for (int k = 1; k <= 3; k++) begin
            cyc(1, 0, 0, 1, 0, 1);
            chk("ilv ch0 y", int'(y_o[2]), k);
            chk("ilv ch0 id", ch_o[2], 0);
            cyc(1, 0, 0, 1, 1, 2);
            chk("ilv ch1 y", int'(y_o[2]), 2 * k);
            chk("ilv ch1 id", ch_o[2], 1);
        end

        // rounding on the FRAC=2 instance
        cyc(1, 1, 0, 0, 0, 0);
        coef(3, 0, 0);
        cyc(1, 0, 0, 1, 0, 5);
        chk("frac x=5", int'(y_o[1]), 4);
        cyc(1, 0, 0, 1, 0, -5);
        chk("frac x=-5", int'(y_o[1]), -4);
        cyc(1, 0, 0, 1, 0, 2);
        chk("frac x=2", int'(y_o[1]), 2);
        cyc(1, 0, 0, 1, 0, -2);
        chk("frac x=-2", int'(y_o[1]), -1);

        // mixed pattern, model-checked only
        for (int i = 0; i < 24; i++) begin
            coef((i % 5) - 2, 3 - (i % 7), (i % 3) - 1);
            cyc(1, (i == 17), (i % 11 == 10), 1'b1,
                (i % 7 == 6) ? 2'd3 : 2'(i % 2), ((i * 5) % 16) - 8);
        end
        cyc(1, 0, 0, 0, 0, 0);

        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iir_mc_filter.md
Name: iir_mc_filter

Overview:
Parametrised, multi-channel first-order IIR filter: y[n] = sat(round((b0·x[n] + b1·x[n-1] + a1·y[n-1]) >>> FRAC)).
- Successor to the fixed 4-bit/8-bit single-channel iir block. Adds configurable widths, fixed-point scaling with rounding, output saturation, a valid handshake, time-interleaved channels with per-channel state, and a state-clear input.
- Sits between a sample source and downstream DSP. Coefficients are shared by all channels.

Parameters:
- XW, 4: signed input sample width.
- CW, 4: signed coefficient width (b0, b1, a1).
- YW, 8: signed output width; also the width of the stored y[n-1].
- FRAC, 0: arithmetic right shift applied to the accumulator (coefficient fractional bits).
- NCH, 1: number of interleaved channels, 1..16.
- CHW, max(1,clog2(NCH)): channel index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- clr  in  1  synchronous clear of all channel state.
- sleep  in  1  freeze: state and outputs hold, inputs ignored.
- in_valid  in  1  x/in_ch are valid this cycle.
- in_ch  in  CHW  channel of x.
- x  in  XW  signed sample.
- b0, b1, a1  in  CW each  signed coefficients, sampled on accepted cycles.
- out_valid  out  1  y/out_ch valid (single-cycle pulse per accepted sample).
- out_ch  out  CHW  channel of y.
- y  out  YW  signed filtered output.
- sat  out  1  y was clipped this sample.
- ch_err  out  1  pulse: in_valid with in_ch >= NCH.

Behaviour:
- All updates occur on posedge clk. Priority order: reset_n=0, then clr, then sleep, then in_valid.
- Reset (reset_n=0): every x_d[c] and y_d[c] = 0; y = 0, out_ch = 0, out_valid = 0, sat = 0, ch_err = 0.
- clr=1: every x_d[c] and y_d[c] = 0; out_valid = 0, ch_err = 0; y, out_ch and sat hold.
- sleep=1: all state and y/out_ch/sat hold; out_valid = 0, ch_err = 0; in_valid is ignored and the sample is lost.
- Accepted sample (in_valid=1, in_ch=c < NCH):
  - acc = b0·x + b1·x_d[c] + a1·y_d[c], computed at full precision. ACCW = max(XW,YW) + CW + 2; no intermediate overflow.
  - If FRAC>0: r = (acc + 2^(FRAC-1)) >>> FRAC (round half up, arithmetic shift). If FRAC=0: r = acc.
  - ynew = r clipped to [-2^(YW-1), 2^(YW-1)-1]; sat = 1 if clipped, else 0.
  - Update x_d[c] <= x, y_d[c] <= ynew (the saturated value is fed back), y <= ynew, out_ch <= c, out_valid <= 1.
  - Latency is 1 cycle: the result is registered at the edge that samples the input.
  - Back-to-back samples on the same channel are allowed every cycle; each sample uses the state written at the previous edge. No hazard.
- in_valid=1 with in_ch >= NCH: no state change; out_valid = 0; ch_err = 1 for one cycle; y/out_ch/sat hold.
- in_valid=0 (not sleeping): out_valid = 0, ch_err = 0; everything else holds.
- Coefficients are not registered. Changing them affects only subsequently accepted samples.
- Channel state is stored in register arrays (no RAM macro); NCH ≤ 16 keeps this acceptable.

Decomposition:
- Package iir_pkg:
  - accumulator-width function acc_w(XW,YW,CW);
  - saturate function sat_clip(value, YW) returning value and flag;
  - round-shift function rnd_shr(value, FRAC).
- Sub-module iir_mac_sat: purely combinational. Takes x, x_d, y_d and the coefficients; produces ynew and the sat flag.
- Top iir_mc_filter: channel state arrays, control priority, output registers.

Test Plan:
- Defaults, b0=3, b1=0, a1=4, x=5 held valid from reset -> y = 15, 75, 127(sat=1), 127(sat=1), ...
- Defaults, zero state, b0=2, b1=-2, a1=-4, x=5 held -> y = 10, -40, 127(sat=1), -128(sat=1); out_valid=1 every cycle.
- NCH=2, b0=1, b1=0, a1=1; inputs interleaved ch0 x=1, ch1 x=2, repeated -> ch0 y = 1,2,3; ch1 y = 2,4,6; out_ch alternates 0,1.
- FRAC=2, b0=3, b1=0, a1=0 -> x=5 gives y=4; x=-5 gives y=-4; x=2 gives y=2 (6+2=8>>>2).
- After test 1 reaches y=75: assert sleep for 3 cycles with in_valid=1 -> out_valid=0, y stays 75; release -> next y=127. Then pulse clr -> next x=5 gives y=15.
- Reset mid-stream, plus ch_err: reset_n=0 for one cycle while valid -> all outputs 0, next sample restarts from zero state. With NCH=2, in_ch=3 -> ch_err pulse, no out_valid, state unchanged.
